nios_audio_system_adc_deserializer: RTL

Captures the serial ADC stream from the board audio codec (I2S format: bit clock, left/right clock, data) and converts it to parallel 16-bit stereo samples in the system clock domain. It sits directly upstream of the Audio_In PIO. Its `audio_sample` output drives the PIO `in_port[15:0]` that the NIOS reads. It also exposes both channels, a per-frame valid strobe and a sticky framing-error flag for other DSP stages.

---
 rtl/nios_audio_system_adc_deserializer_if.sv | 43 ++++
 rtl/nios_audio_system_adc_deserializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_audio_system_adc_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_audio_system_adc_deserializer_if
// Description : Codec serial inputs and parallel stereo sample outputs of the
//               ADC deserializer, bundled as one bus.
//               master = deserializer, slave = codec driver / sample consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_audio_system_adc_deserializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  aud_bclk;
  logic                  aud_adclrck;
  logic                  aud_adcdat;
  logic [DATA_WIDTH-1:0] left_sample;
  logic [DATA_WIDTH-1:0] right_sample;
  logic [DATA_WIDTH-1:0] audio_sample;
  logic                  sample_valid;
  logic                  frame_error;

  modport master (
    input  aud_bclk,
    input  aud_adclrck,
    input  aud_adcdat,
    output left_sample,
    output right_sample,
    output audio_sample,
    output sample_valid,
    output frame_error
  );

  modport slave (
    output aud_bclk,
    output aud_adclrck,
    output aud_adcdat,
    input  left_sample,
    input  right_sample,
    input  audio_sample,
    input  sample_valid,
    input  frame_error
  );
endinterface
`default_nettype wire

// File: rtl/nios_audio_system_adc_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : nios_audio_system_adc_deserializer
// Description : I2S / left-justified ADC stream deserializer. Synchronizes the
//               codec BCLK/LRCK/DATA into clk, assembles DATA_WIDTH-bit words
//               MSB first and presents registered stereo samples plus a
//               selectable channel / (L+R)/2 mix for the Audio_In PIO.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_audio_system_adc_deserializer #(
  parameter int DATA_WIDTH = 16,
  parameter int I2S_DELAY  = 1,
  parameter int OUT_MODE   = 2
) (
  input  wire clk,
  input  wire reset,
  nios_audio_system_adc_deserializer_if.master bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [CW-1:0] c_width   = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_WAIT_EDGE = 2'd0,
    S_DELAY     = 2'd1,
    S_SHIFT     = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  // synchronizer stages
  logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic r_lrck_s1, r_lrck_s2;
  logic r_dat_s1,  r_dat_s2;

  // capture state
  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_bit_cnt;
  logic [CW-1:0]         w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_next;
  logic                  r_lrck_prev;
  logic [DATA_WIDTH-1:0] r_left_stage;
  logic                  r_left_stage_vld;
  logic [DATA_WIDTH-1:0] r_right_stage;
  logic                  r_right_done;
  logic                  r_frame_error;

  // output registers
  logic [DATA_WIDTH-1:0] r_left_sample;
  logic [DATA_WIDTH-1:0] r_right_sample;
  logic [DATA_WIDTH-1:0] r_audio_sample;
  logic                  r_sample_valid;
  logic [DATA_WIDTH-1:0] w_audio_sel;

  logic w_bclk_rise;
  logic w_lrck_edge;
  logic w_shift_en;
  logic w_shift_first;
  logic w_set_err;
  logic w_restart;
  logic w_complete;

  assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_s3;
  assign w_lrck_edge  = w_bclk_rise & (r_lrck_s2 != r_lrck_prev);
  assign w_shreg_next = {r_shreg[DATA_WIDTH-2:0], r_dat_s2};

  // Bring the three asynchronous codec lines into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_s3 <= 1'b0;
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_dat_s1  <= 1'b0;
      r_dat_s2  <= 1'b0;
    end else begin
      r_bclk_s1 <= bus.aud_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
      r_lrck_s1 <= bus.aud_adclrck;
      r_lrck_s2 <= r_lrck_s1;
      r_dat_s1  <= bus.aud_adcdat;
      r_dat_s2  <= r_dat_s1;
    end
  end

  // Capture state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WAIT_EDGE;
    else       r_state <= w_state_next;
  end

  // Next-state and per-bit control. The rise on which the LRCK edge is seen is
  // itself the I2S delay bit, so DELAY shifts the MSB on the following rise.
  always_comb begin
    w_state_next  = r_state;
    w_shift_en    = 1'b0;
    w_shift_first = 1'b0;
    w_set_err     = 1'b0;
    w_restart     = 1'b0;
    if (w_bclk_rise) begin
      case (r_state)
        S_WAIT_EDGE, S_DONE: begin
          if (w_lrck_edge) w_restart = 1'b1;
        end
        S_DELAY: begin
          if (w_lrck_edge) begin
            w_set_err = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_state_next  = S_SHIFT;
            w_shift_en    = 1'b1;
            w_shift_first = 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_lrck_edge) begin
            w_set_err = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_shift_en = 1'b1;
          end
        end
        default: w_state_next = S_WAIT_EDGE;
      endcase
    end
    if (w_restart) begin
      if (I2S_DELAY != 0) begin
        w_state_next = S_DELAY;
      end else begin
        w_state_next  = S_SHIFT;
        w_shift_en    = 1'b1;
        w_shift_first = 1'b1;
      end
    end
    w_cnt_inc  = w_shift_first ? c_cnt_one : r_bit_cnt + c_cnt_one;
    w_complete = w_shift_en && (w_cnt_inc == c_width);
    if (w_complete) w_state_next = S_DONE;
  end

  // Shift register, bit counter and per-channel staging. The channel of a
  // completed word is taken from lrck_s2, which equals lrck_prev whenever no
  // edge is present on the completing rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg          <= '0;
      r_bit_cnt        <= '0;
      r_lrck_prev      <= 1'b0;
      r_left_stage     <= '0;
      r_left_stage_vld <= 1'b0;
      r_right_stage    <= '0;
      r_right_done     <= 1'b0;
      r_frame_error    <= 1'b0;
    end else begin
      r_right_done <= 1'b0;
      if (w_bclk_rise) begin
        r_lrck_prev <= r_lrck_s2;
        if (w_shift_en) begin
          r_shreg   <= w_shreg_next;
          r_bit_cnt <= w_cnt_inc;
        end else if (w_restart) begin
          r_bit_cnt <= '0;
        end
        if (w_complete) begin
          if (!r_lrck_s2) begin
            r_left_stage     <= w_shreg_next;
            r_left_stage_vld <= 1'b1;
          end else begin
            r_right_stage <= w_shreg_next;
            r_right_done  <= 1'b1;
          end
        end
        if (w_set_err) r_frame_error <= 1'b1;
      end
    end
  end

  // Audio_In source selection
  generate
    if (OUT_MODE == 0) begin : g_out_left
      assign w_audio_sel = r_left_stage;
    end else if (OUT_MODE == 1) begin : g_out_right
      assign w_audio_sel = r_right_stage;
    end else begin : g_out_mix
      // Sign-extended sum, arithmetic halving truncates toward -inf.
      logic signed [DATA_WIDTH:0] w_mix_sum;
      assign w_mix_sum = $signed({r_left_stage[DATA_WIDTH-1], r_left_stage})
                       + $signed({r_right_stage[DATA_WIDTH-1], r_right_stage});
      assign w_audio_sel = DATA_WIDTH'(w_mix_sum >>> 1);
    end
  endgenerate

  // Load the stereo pair when a right word completes after a valid left word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_left_sample  <= '0;
      r_right_sample <= '0;
      r_audio_sample <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (r_right_done && r_left_stage_vld) begin
        r_left_sample  <= r_left_stage;
        r_right_sample <= r_right_stage;
        r_audio_sample <= w_audio_sel;
        r_sample_valid <= 1'b1;
      end
    end
  end

  assign bus.left_sample  = r_left_sample;
  assign bus.right_sample = r_right_sample;
  assign bus.audio_sample = r_audio_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.frame_error  = r_frame_error;

endmodule
`default_nettype wire
